pe_cluster_scheduler: RTL

Sequences one PE cluster through repeated load / compute / partial-sum drain passes. Broadcasts load-enable and write-finish strobes to every PE controller in the cluster, gathers each PE's calculation-finish pulse, then drains partial sums one PE at a time under a downstream ready. It sits between the cluster-level top controller and the per-PE controllers, and reports completion of a multi-pass job with a one-cycle `done`.

---
 rtl/pe_cluster_scheduler_if.sv | 33 +++
 rtl/pe_cluster_scheduler.sv | 118 +++++++++++
 2 files changed

// File: rtl/pe_cluster_scheduler_if.sv
// Handshake bundle between the cluster top controller, the scheduler
// and the per-PE controllers.
interface pe_cluster_scheduler_if #(
  parameter int NUM_PE = 12,
  parameter int PASS_W = 8
);
  logic              start;
  logic [PASS_W-1:0] num_pass;
  logic              abort;
  logic              glb_load_done;
  logic [NUM_PE-1:0] pe_cal_fin;
  logic              psum_ready;
  logic [NUM_PE-1:0] pe_do_load_en;
  logic [NUM_PE-1:0] pe_write_fin;
  logic [NUM_PE-1:0] pe_psum_enq_en;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output start, num_pass, abort,
    output glb_load_done, pe_cal_fin, psum_ready,
    input  pe_do_load_en, pe_write_fin,
    input  pe_psum_enq_en, busy, done, pass_idx
  );

  modport slave (
    input  start, num_pass, abort,
    input  glb_load_done, pe_cal_fin, psum_ready,
    output pe_do_load_en, pe_write_fin,
    output pe_psum_enq_en, busy, done, pass_idx
  );
endinterface

// File: rtl/pe_cluster_scheduler.sv
// Runs one PE cluster through load / compute / psum-drain passes
// and pulses done when the whole multi-pass job is finished.
module pe_cluster_scheduler #(
  parameter int NUM_PE = 12,
  parameter int PASS_W = 8
) (
  input logic                    clock,
  input logic                    reset,
  pe_cluster_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_PE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_REQ  = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_CAL       = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [NUM_PE-1:0] fin_mask_q, fin_mask_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [PASS_W-1:0] num_pass_q, num_pass_d;
  logic [NUM_PE-1:0] fin_all;

  always_comb begin
    state_d    = state_q;
    fin_mask_d = fin_mask_q;
    ptr_d      = ptr_q;
    pass_idx_d = pass_idx_q;
    num_pass_d = num_pass_q;
    fin_all    = fin_mask_q | bus.pe_cal_fin;
    if (bus.abort) begin
      state_d    = S_IDLE;
      fin_mask_d = '0;
      ptr_d      = '0;
      pass_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_pass != '0) begin
              num_pass_d = bus.num_pass;
              pass_idx_d = '0;
              state_d    = S_LOAD_REQ;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_LOAD_REQ: state_d = S_LOAD_WAIT;
        S_LOAD_WAIT: begin
          if (bus.glb_load_done) begin
            fin_mask_d = '0;
            state_d    = S_CAL;
          end
        end
        S_CAL: begin
          fin_mask_d = fin_all;
          if (&fin_all) begin
            ptr_d   = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.psum_ready) begin
            if (ptr_q == PTR_LAST) begin
              ptr_d = '0;
              if (pass_idx_q == num_pass_q - PASS_W'(1)) begin
                state_d = S_DONE;
              end else begin
                pass_idx_d = pass_idx_q + PASS_W'(1);
                state_d    = S_LOAD_REQ;
              end
            end else begin
              ptr_d = ptr_q + PTR_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fin_mask_q <= '0;
      ptr_q      <= '0;
      pass_idx_q <= '0;
      num_pass_q <= '0;
    end else begin
      state_q    <= state_d;
      fin_mask_q <= fin_mask_d;
      ptr_q      <= ptr_d;
      pass_idx_q <= pass_idx_d;
      num_pass_q <= num_pass_d;
    end
  end

  // Abort masks every strobe in its own cycle.
  logic act;
  assign act = ~bus.abort;

  assign bus.pe_do_load_en =
    {NUM_PE{act && state_q == S_LOAD_REQ}};
  assign bus.pe_write_fin =
    {NUM_PE{act && state_q == S_LOAD_WAIT && bus.glb_load_done}};
  assign bus.pe_psum_enq_en =
    (act && state_q == S_DRAIN && bus.psum_ready)
      ? (NUM_PE'(1) << ptr_q) : '0;
  assign bus.busy     = state_q != S_IDLE;
  assign bus.done     = act && state_q == S_DONE;
  assign bus.pass_idx = pass_idx_q;
endmodule
